// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Bundles the pipeline controller's handshake and bus signals:
//               stall requests, branch/EX info, timer trap inputs, the stall
//               vector, the flush pulse, the PC redirect and the CSR trap writes.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;
    logic        rdy_in;
    logic        stallreq_if_in;
    logic        stallreq_id_in;
    logic        stallreq_mem_in;
    logic        branch_flag_in;
    logic [31:0] branch_target_in;
    logic        ex_valid_in;
    logic [31:0] pc_ex_in;
    logic        timer_irq_in;
    logic        irq_enable_in;
    logic [31:0] mtvec_in;
    logic [5:0]  stall;
    logic        timer_interrupt;
    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;
    logic        mepc_we_out;
    logic [31:0] mepc_out;
    logic [31:0] mcause_out;

    // Controller side
    modport slave (
        input  rdy_in, stallreq_if_in, stallreq_id_in, stallreq_mem_in,
        input  branch_flag_in, branch_target_in, ex_valid_in, pc_ex_in,
        input  timer_irq_in, irq_enable_in, mtvec_in,
        output stall, timer_interrupt, redirect_valid_out, redirect_pc_out,
        output mepc_we_out, mepc_out, mcause_out
    );

    // Pipeline / driver side
    modport master (
        output rdy_in, stallreq_if_in, stallreq_id_in, stallreq_mem_in,
        output branch_flag_in, branch_target_in, ex_valid_in, pc_ex_in,
        output timer_irq_in, irq_enable_in, mtvec_in,
        input  stall, timer_interrupt, redirect_valid_out, redirect_pc_out,
        input  mepc_we_out, mepc_out, mcause_out
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline stall arbitration, branch/trap PC redirect and
//               precise timer-interrupt entry (waits until EX holds a real,
//               unstalled, non-branching instruction, then flushes it).
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl (
    input  wire logic       clk_in,
    input  wire logic       rst_in,
    pipeline_ctrl_if.slave  bus
);

    localparam logic [31:0] c_MCAUSE_TIMER = 32'h8000_0007;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_trap_fire;
    logic        w_irq_req;
    logic        w_no_stall_req;
    logic        r_mepc_we;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;

    assign w_irq_req      = bus.timer_irq_in & bus.irq_enable_in;
    assign w_no_stall_req = ~(bus.stallreq_if_in | bus.stallreq_id_in | bus.stallreq_mem_in);

    // Stall vector: the deepest requesting stage wins, independent of trap state
    always_comb begin
        bus.stall = 6'b000000;
        if (bus.stallreq_mem_in) begin
            bus.stall = 6'b011111;
        end else if (bus.stallreq_id_in) begin
            bus.stall = 6'b000111;
        end else if (bus.stallreq_if_in) begin
            bus.stall = 6'b000011;
        end
    end

    // Trap FSM next state and fire decision; nothing moves while rdy_in is low
    always_comb begin
        w_state_nxt = r_state;
        w_trap_fire = 1'b0;
        if (bus.rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_irq_req) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_irq_req) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_no_stall_req && bus.ex_valid_in && !bus.branch_flag_in) begin
                        w_trap_fire = 1'b1;
                        w_state_nxt = ST_COOL;
                    end
                end
                ST_COOL: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // CSR trap writes: one-cycle mepc strobe after fire, values held otherwise
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mepc_we <= 1'b0;
            r_mepc    <= 32'h0;
            r_mcause  <= 32'h0;
        end else if (bus.rdy_in) begin
            r_mepc_we <= w_trap_fire;
            if (w_trap_fire) begin
                r_mepc   <= bus.pc_ex_in;
                r_mcause <= c_MCAUSE_TIMER;
            end
        end
    end

    // Redirect: a trap vector beats a branch target (fire already excludes a branch)
    always_comb begin
        bus.redirect_pc_out = 32'h0;
        if (w_trap_fire) begin
            bus.redirect_pc_out = bus.mtvec_in;
        end else if (bus.branch_flag_in) begin
            bus.redirect_pc_out = bus.branch_target_in;
        end
    end

    assign bus.redirect_valid_out = w_trap_fire | bus.branch_flag_in;
    assign bus.timer_interrupt    = w_trap_fire;
    assign bus.mepc_we_out        = r_mepc_we;
    assign bus.mepc_out           = r_mepc;
    assign bus.mcause_out         = r_mcause;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl with a
//               flag-based reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: "waiting" = timer request accepted, trap not yet taken;
    // "cooling" = the cycle right after a trap.
    logic        m_waiting;
    logic        m_cooling;
    logic        m_we;
    logic [31:0] m_epc;
    logic [31:0] m_cause;

    function automatic logic [5:0] exp_stall();
        if (bus.stallreq_mem_in) return 6'b011111;
        if (bus.stallreq_id_in)  return 6'b000111;
        if (bus.stallreq_if_in)  return 6'b000011;
        return 6'b000000;
    endfunction

    function automatic logic exp_fire();
        return m_waiting && bus.rdy_in && !bus.stallreq_if_in && !bus.stallreq_id_in &&
               !bus.stallreq_mem_in && bus.ex_valid_in && !bus.branch_flag_in &&
               bus.timer_irq_in && bus.irq_enable_in;
    endfunction

    // Model update
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_waiting <= 1'b0;
            m_cooling <= 1'b0;
            m_we      <= 1'b0;
            m_epc     <= 32'h0;
            m_cause   <= 32'h0;
        end else if (bus.rdy_in) begin
            m_we <= exp_fire();
            if (exp_fire()) begin
                m_epc   <= bus.pc_ex_in;
                m_cause <= 32'h8000_0007;
            end
            if (m_cooling) begin
                m_cooling <= 1'b0;
            end else if (m_waiting) begin
                if (exp_fire()) begin
                    m_waiting <= 1'b0;
                    m_cooling <= 1'b1;
                end else if (!(bus.timer_irq_in && bus.irq_enable_in)) begin
                    m_waiting <= 1'b0;
                end
            end else if (bus.timer_irq_in && bus.irq_enable_in) begin
                m_waiting <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk_in) begin
        logic        f;
        logic [31:0] rp;
        f  = exp_fire();
        rp = f ? bus.mtvec_in : (bus.branch_flag_in ? bus.branch_target_in : 32'h0);
        check("m_stall",    {26'h0, bus.stall},              {26'h0, exp_stall()});
        check("m_tint",     {31'h0, bus.timer_interrupt},    {31'h0, f});
        check("m_rvalid",   {31'h0, bus.redirect_valid_out}, {31'h0, f | bus.branch_flag_in});
        check("m_rpc",      bus.redirect_pc_out,             rp);
        check("m_mepc_we",  {31'h0, bus.mepc_we_out},        {31'h0, m_we});
        check("m_mepc",     bus.mepc_out,                    m_epc);
        check("m_mcause",   bus.mcause_out,                  m_cause);
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic quiet();
        bus.rdy_in = 1'b1;
        bus.stallreq_if_in = 1'b0;
        bus.stallreq_id_in = 1'b0;
        bus.stallreq_mem_in = 1'b0;
        bus.branch_flag_in = 1'b0;
        bus.branch_target_in = 32'h0;
        bus.ex_valid_in = 1'b0;
        bus.pc_ex_in = 32'h0;
        bus.timer_irq_in = 1'b0;
        bus.irq_enable_in = 1'b0;
        bus.mtvec_in = 32'h200;
    endtask

    task automatic raise_irq(input logic [31:0] pc);
        bus.timer_irq_in = 1'b1;
        bus.irq_enable_in = 1'b1;
        bus.ex_valid_in = 1'b1;
        bus.pc_ex_in = pc;
    endtask

    initial begin
        quiet();
        bus.rdy_in = 1'b0;
        bus.mtvec_in = 32'h0;
        #2;
        // Reset state with all inputs low
        check("rst_stall", {26'h0, bus.stall}, 32'h0);
        check("rst_rvalid", {31'h0, bus.redirect_valid_out}, 32'h0);
        check("rst_rpc", bus.redirect_pc_out, 32'h0);
        check("rst_we", {31'h0, bus.mepc_we_out}, 32'h0);
        check("rst_mepc", bus.mepc_out, 32'h0);
        check("rst_mcause", bus.mcause_out, 32'h0);
        step(); step();
        rst_in = 1'b1;
        quiet();
        step();

        // Stall priority
        bus.stallreq_mem_in = 1'b1; bus.stallreq_id_in = 1'b1; #1;
        check("stall_mem_id", {26'h0, bus.stall}, 32'h1f);
        bus.stallreq_mem_in = 1'b0; bus.stallreq_if_in = 1'b1; #1;
        check("stall_id_if", {26'h0, bus.stall}, 32'h07);
        bus.stallreq_id_in = 1'b0; #1;
        check("stall_if", {26'h0, bus.stall}, 32'h03);
        quiet();
        step();

        // Basic trap entry
        raise_irq(32'h1000);
        #1 check("t1_idle_nofire", {31'h0, bus.timer_interrupt}, 32'h0);
        step();
        #1 check("t1_fire", {31'h0, bus.timer_interrupt}, 32'h1);
        check("t1_vec", bus.redirect_pc_out, 32'h200);
        step();
        quiet();
        #1 check("t1_we", {31'h0, bus.mepc_we_out}, 32'h1);
        check("t1_mepc", bus.mepc_out, 32'h1000);
        check("t1_mcause", bus.mcause_out, 32'h8000_0007);
        check("t1_cool_nofire", {31'h0, bus.timer_interrupt}, 32'h0);
        step();
        #1 check("t1_we_pulse", {31'h0, bus.mepc_we_out}, 32'h0);

        // Memory stall holds the trap off for three cycles
        raise_irq(32'h2000);
        bus.stallreq_mem_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1 check("t2_held", {31'h0, bus.timer_interrupt}, 32'h0);
        end
        step();
        bus.stallreq_mem_in = 1'b0;
        #1 check("t2_fire", {31'h0, bus.timer_interrupt}, 32'h1);
        step();
        quiet();
        #1 check("t2_mepc", bus.mepc_out, 32'h2000);

        // Branch wins over trap
        step();
        raise_irq(32'h3000);
        bus.branch_flag_in = 1'b1;
        bus.branch_target_in = 32'h400;
        step();
        #1 check("t3_br_pc", bus.redirect_pc_out, 32'h400);
        check("t3_br_noint", {31'h0, bus.timer_interrupt}, 32'h0);
        step();
        bus.branch_flag_in = 1'b0;
        #1 check("t3_late_fire", {31'h0, bus.timer_interrupt}, 32'h1);
        check("t3_late_vec", bus.redirect_pc_out, 32'h200);
        step();
        quiet();
        #1 check("t3_mepc", bus.mepc_out, 32'h3000);

        // Interrupt withdrawn while draining
        step();
        raise_irq(32'h4000);
        bus.ex_valid_in = 1'b0;
        step();
        bus.timer_irq_in = 1'b0;
        bus.ex_valid_in = 1'b1;
        step(); step();
        #1 check("t4_no_we", {31'h0, bus.mepc_we_out}, 32'h0);
        check("t4_mepc_hold", bus.mepc_out, 32'h3000);

        // Global ready low freezes everything
        quiet();
        raise_irq(32'h5000);
        bus.ex_valid_in = 1'b0;
        step();
        bus.rdy_in = 1'b0;
        bus.ex_valid_in = 1'b1;
        #1 check("t5_frozen_nofire", {31'h0, bus.timer_interrupt}, 32'h0);
        step();
        bus.rdy_in = 1'b1;
        #1 check("t5_fire", {31'h0, bus.timer_interrupt}, 32'h1);
        step();
        bus.rdy_in = 1'b0;
        bus.timer_irq_in = 1'b0;
        step();
        #1 check("t5_we_held", {31'h0, bus.mepc_we_out}, 32'h1);
        bus.rdy_in = 1'b1;
        step();
        #1 check("t5_we_drop", {31'h0, bus.mepc_we_out}, 32'h0);
        check("t5_mepc", bus.mepc_out, 32'h5000);

        // Reset during COOL
        raise_irq(32'h6000);
        step();
        step();
        quiet();
        rst_in = 1'b0;
        #1 check("t6_rst_we", {31'h0, bus.mepc_we_out}, 32'h0);
        check("t6_rst_mepc", bus.mepc_out, 32'h0);
        step();
        raise_irq(32'h7000);
        rst_in = 1'b1;
        #1 check("t6_fresh_idle", {31'h0, bus.timer_interrupt}, 32'h0);
        step();
        #1 check("t6_fresh_fire", {31'h0, bus.timer_interrupt}, 32'h1);
        step();
        quiet();
        step(); step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
